count_wrap_monitor: RTL
=======================

Name: count_wrap_monitor

Overview:
- Downstream observer for the 4-bit up(+3)/down(-5)/load counter.
- Samples the counter output together with the same control inputs the counter received.
- Predicts each next count and flags any mismatch (sticky fault).
- Emits one-cycle wrap-around pulses and keeps a saturating wrap tally for status/display logic further down the chain.

Parameters:
- UP_STEP, 3, increment applied when enable=0, up_downBar=1.
- DOWN_STEP, 5, decrement applied when enable=0, up_downBar=0.
- WRAP_W, 8, width of saturating wrap counter.

Ports:
- clk  input  1  rising-edge clock, shared with counter.
- clearBar  input  1  asynchronous active-low reset.
- cnt_in  input  4  counter output value.
- load_val  input  4  counter's parallel-load input.
- enable  input  1  counter load control, same net as counter.
- up_downBar  input  1  counter direction, same net as counter.
- fault_clr  input  1  synchronous clear of sticky fault, returns FSM to SYNC.
- wrap_up  output  1  one-cycle pulse: up-step overflowed past 15.
- wrap_down  output  1  one-cycle pulse: down-step underflowed below 0.
- wrap_count  output  WRAP_W  saturating count of wrap events.
- mismatch  output  1  sticky: observed count differed from predicted.
- exp_cnt  output  4  last predicted value (debug).
- state  output  2  FSM state encoding.

Behaviour:
- Reset: clearBar=0 asynchronously forces state=SYNC, all outputs 0, and internal sample regs 0.
- Sample model: at each rising edge k, capture S_k={cnt_in, load_val, enable, up_downBar}. The counter's response to the controls at edge k appears on cnt_in at edge k+1.
- Prediction: from S_{k-1}:
  - enable=1 -> pred = load_val.
  - enable=0, up_downBar=1 -> pred = (cnt+UP_STEP) mod 16.
  - enable=0, up_downBar=0 -> pred = (cnt-DOWN_STEP) mod 16.
  - Compute at 5 bits; low 4 bits are pred, carry/borrow bit is the wrap.
- Wraps are reported only when enable=0 in S_{k-1}; a load never counts as a wrap.
- FSM states: SYNC=2'b00, TRACK=2'b01, FAULT=2'b10.
- SYNC:
  - First edge after reset or fault_clr only captures a sample.
  - No compare; no wrap pulses.
  - Next edge -> TRACK.
- TRACK, each edge:
  - exp_cnt <= pred.
  - If cnt_in != pred: mismatch <= 1, -> FAULT.
  - Else: wrap_up/wrap_down <= carry/borrow for one cycle.
  - On a wrap, wrap_count increments and saturates at all-ones.
- FAULT:
  - mismatch held at 1; wraps not reported.
  - wrap_count frozen; capture continues.
  - fault_clr=1 -> mismatch <= 0, -> SYNC. wrap_count is not cleared; only reset clears it.
- fault_clr in SYNC/TRACK: forces SYNC, clears mismatch; wrap_count kept.
- Latency: wrap_up/wrap_down/mismatch assert on the edge where the offending cnt_in is sampled, i.e. one clock after the counter updated.
- Pulse width: wrap_up and wrap_down are never simultaneously 1; each is 1 for exactly one cycle per event. Back-to-back wraps give consecutive pulses.
- Reset mid-operation: immediate return to reset values. Post-reset counter value 0 is accepted via SYNC; no false mismatch.
- Unused state 2'b11 -> SYNC on next edge.

Decomposition:
- Shared package/header holds:
  - FSM state localparams (SYNC, TRACK, FAULT).
  - UP_STEP/DOWN_STEP defaults, matching the counter.
  - Counter width constant (4).
- One natural sub-module: count_step_predictor, combinational. Inputs are the sampled cnt, load_val, enable and up_downBar; outputs are pred[3:0], carry and borrow. It is reusable by the counter's own bench as a reference model.

Test Plan:
- Reset then up-count from 0: sequence 0,3,6,9,12,15,2 -> wrap_up pulse exactly on the edge sampling 2; wrap_count=1; mismatch=0.
- Down-count from 2: sequence 2,13,8,3,14 -> wrap_down pulses on edges sampling 13 and 14; wrap_count=2.
- Load: enable=1, load_val=4'hA while cnt_in=14 -> next cnt_in=10 accepted; no wrap pulse although 14+3 would overflow.
- Fault: in TRACK, inject cnt_in=7 where 9 expected -> mismatch=1, state=FAULT, exp_cnt=9. Further wraps are ignored. fault_clr for 1 cycle -> mismatch=0, SYNC, then TRACK; wrap_count unchanged.
- Saturation (WRAP_W=2): 5 consecutive up-wraps -> wrap_count sticks at 3; pulses still fire.
- Async reset: assert clearBar between edges mid-TRACK -> all outputs 0 immediately. Release with cnt_in=0 -> no mismatch on the following two edges.

Source files
------------

// File: rtl/count_wrap_monitor_pkg.sv
// rtl/count_wrap_monitor_pkg.sv - shared constants and FSM state type for the count wrap monitor
package count_wrap_monitor_pkg;

   // Width of the observed counter; the predictor and monitor assume 4 bits.
   localparam int CNT_W = 4;

   // Step sizes of the upstream counter; these must track the counter itself.
   localparam int UP_STEP_DEF   = 3;
   localparam int DOWN_STEP_DEF = 5;

   // Default width of the saturating wrap tally.
   localparam int WRAP_W_DEF = 8;

   // Monitor FSM. The encoding is visible on the state output, so values are fixed.
   // 2'b11 is never entered; if it ever appears, the FSM falls back to SYNC.
   typedef enum logic [1:0] {
      SYNC  = 2'b00,
      TRACK = 2'b01,
      FAULT = 2'b10
   } mon_state_t;

endpackage

// File: rtl/count_step_predictor.sv
// rtl/count_step_predictor.sv - combinational next-count model of the up/down/load counter
module count_step_predictor
   import count_wrap_monitor_pkg::*;
#(
   parameter int UP_STEP   = UP_STEP_DEF,
   parameter int DOWN_STEP = DOWN_STEP_DEF
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] load_val,
   input  logic             enable,
   input  logic             up_downBar,
   output logic [CNT_W-1:0] pred,
   output logic             carry,
   output logic             borrow
);

   // One extra bit so the top bit of the sum/difference is the carry/borrow.
   localparam logic [CNT_W:0] UP_EXT   = (CNT_W+1)'(UP_STEP);
   localparam logic [CNT_W:0] DOWN_EXT = (CNT_W+1)'(DOWN_STEP);

   logic [CNT_W:0] up_sum;
   logic [CNT_W:0] down_diff;

   assign up_sum    = {1'b0, cnt} + UP_EXT;
   assign down_diff = {1'b0, cnt} - DOWN_EXT;

   // Select the counter's next value; a parallel load never reports a wrap.
   always_comb begin
      pred   = cnt;
      carry  = 1'b0;
      borrow = 1'b0;
      if (enable) begin
         pred = load_val;
      end else if (up_downBar) begin
         pred  = up_sum[CNT_W-1:0];
         carry = up_sum[CNT_W];
      end else begin
         pred   = down_diff[CNT_W-1:0];
         borrow = down_diff[CNT_W];
      end
   end

endmodule

// File: rtl/count_wrap_monitor.sv
// rtl/count_wrap_monitor.sv - checks the 4-bit counter against its controls and reports wrap-arounds
module count_wrap_monitor
   import count_wrap_monitor_pkg::*;
#(
   parameter int UP_STEP   = UP_STEP_DEF,
   parameter int DOWN_STEP = DOWN_STEP_DEF,
   parameter int WRAP_W    = WRAP_W_DEF
) (
   input  logic              clk,
   input  logic              clearBar,
   input  logic [CNT_W-1:0]  cnt_in,
   input  logic [CNT_W-1:0]  load_val,
   input  logic              enable,
   input  logic              up_downBar,
   input  logic              fault_clr,
   output logic              wrap_up,
   output logic              wrap_down,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              mismatch,
   output logic [CNT_W-1:0]  exp_cnt,
   output logic [1:0]        state
);

   // Previous-edge sample of the counter output and the controls it was given.
   logic [CNT_W-1:0] s_cnt;
   logic [CNT_W-1:0] s_load_val;
   logic             s_enable;
   logic             s_up_downBar;

   logic [CNT_W-1:0] pred;
   logic             carry;
   logic             borrow;

   mon_state_t       cur_state;

   assign state = cur_state;

   // The controls seen at the previous edge decide what cnt_in must be now.
   count_step_predictor #(
      .UP_STEP   (UP_STEP),
      .DOWN_STEP (DOWN_STEP)
   ) u_predictor (
      .cnt        (s_cnt),
      .load_val   (s_load_val),
      .enable     (s_enable),
      .up_downBar (s_up_downBar),
      .pred       (pred),
      .carry      (carry),
      .borrow     (borrow)
   );

   // Capture the counter output and its controls on every edge, in every state.
   always_ff @(posedge clk or negedge clearBar) begin
      if (!clearBar) begin
         s_cnt        <= '0;
         s_load_val   <= '0;
         s_enable     <= 1'b0;
         s_up_downBar <= 1'b0;
      end else begin
         s_cnt        <= cnt_in;
         s_load_val   <= load_val;
         s_enable     <= enable;
         s_up_downBar <= up_downBar;
      end
   end

   // Sync/track/fault sequencing with registered compare, wrap pulses and tally.
   always_ff @(posedge clk or negedge clearBar) begin
      if (!clearBar) begin
         cur_state  <= SYNC;
         wrap_up    <= 1'b0;
         wrap_down  <= 1'b0;
         wrap_count <= '0;
         mismatch   <= 1'b0;
         exp_cnt    <= '0;
      end else begin
         // Pulses last a single cycle unless re-armed below.
         wrap_up   <= 1'b0;
         wrap_down <= 1'b0;
         if (fault_clr) begin
            // Re-synchronise from any state; the wrap tally survives.
            mismatch  <= 1'b0;
            cur_state <= SYNC;
         end else begin
            case (cur_state)
               SYNC: begin
                  // This edge only seeds the sample registers.
                  cur_state <= TRACK;
               end
               TRACK: begin
                  exp_cnt <= pred;
                  if (cnt_in != pred) begin
                     mismatch  <= 1'b1;
                     cur_state <= FAULT;
                  end else begin
                     wrap_up   <= carry;
                     wrap_down <= borrow;
                     if ((carry || borrow) && (wrap_count != {WRAP_W{1'b1}})) begin
                        wrap_count <= wrap_count + 1'b1;
                     end
                  end
               end
               FAULT: begin
                  mismatch  <= 1'b1;
                  cur_state <= FAULT;
               end
               default: begin
                  cur_state <= SYNC;
               end
            endcase
         end
      end
   end

endmodule
